// File: rtl/mac_accumulator.sv
// Saturating accumulation stage behind the MAC multiplier: sums a programmed
// number of unsigned products and hands the result downstream over valid/ready.
module mac_accumulator #(
  parameter int MUL_WIDTH   = 32,
  parameter int ACC_WIDTH   = 40,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] num_terms,
  input  logic [MUL_WIDTH-1:0]   mul_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [ACC_WIDTH-1:0]   acc_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   overflow,
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {ACC_WIDTH{1'b1}};

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] num_terms_q, num_terms_d;
  logic                   overflow_q, overflow_d;

  // One spare bit catches the carry out of the accumulator width.
  logic [ACC_WIDTH:0]     sum_full;
  logic                   accept;
  logic                   last_term;

  assign sum_full  = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - MUL_WIDTH){1'b0}}, mul_in};
  assign accept    = (state_q == S_ACCUM) && in_valid;
  assign last_term = (count_q == (num_terms_q - COUNT_WIDTH'(1)));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    num_terms_d = num_terms_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          num_terms_d = num_terms;
          acc_d       = '0;
          count_d     = '0;
          overflow_d  = 1'b0;
          state_d     = (num_terms == '0) ? S_HOLD : S_ACCUM;
        end
      end

      S_ACCUM: begin
        if (accept) begin
          count_d = count_q + COUNT_WIDTH'(1);
          if (sum_full[ACC_WIDTH]) begin
            acc_d      = ACC_MAX;
            overflow_d = 1'b1;
          end else begin
            acc_d = sum_full[ACC_WIDTH-1:0];
          end
          if (last_term) begin
            state_d = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      num_terms_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      num_terms_q <= num_terms_d;
      overflow_q  <= overflow_d;
    end
  end

  // Outputs decode registered state only, so no input reaches them combinationally.
  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_HOLD);
  assign busy      = (state_q != S_IDLE);
  assign acc_out   = acc_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator with a sum-based reference model checked every cycle.
module tb_mac_accumulator;

  localparam int MUL_WIDTH   = 32;
  localparam int ACC_WIDTH   = 34;
  localparam int COUNT_WIDTH = 8;
  localparam logic [63:0] ACC_MAX = (64'd1 << ACC_WIDTH) - 64'd1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic [COUNT_WIDTH-1:0] num_terms = '0;
  logic [MUL_WIDTH-1:0]   mul_in = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [ACC_WIDTH-1:0]   acc_out;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic                   overflow;
  logic                   busy;

  mac_accumulator #(
    .MUL_WIDTH  (MUL_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num_terms(num_terms),
    .mul_in   (mul_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .acc_out  (acc_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase of the transaction plus the true (unsaturated) total of
  // accepted products; the result is the total clipped to the accumulator range.
  int          m_phase  = 0;  // 0 idle, 1 collecting, 2 presenting
  int          m_target = 0;
  int          m_got    = 0;
  logic [63:0] m_total  = 64'd0;
  bit          live     = 1'b0;

  function automatic logic [63:0] clip(input logic [63:0] t);
    return (t > ACC_MAX) ? ACC_MAX : t;
  endfunction

  always @(posedge clk) begin
    edge_cnt++;
    if (rst) begin
      live    = 1'b1;
      m_phase = 0;
      m_got   = 0;
      m_total = 64'd0;
    end else begin
      case (m_phase)
        0: if (start) begin
             m_target = int'(num_terms);
             m_got    = 0;
             m_total  = 64'd0;
             m_phase  = (m_target == 0) ? 2 : 1;
           end
        1: if (in_valid) begin
             m_total = m_total + 64'(mul_in);
             m_got++;
             if (m_got == m_target) m_phase = 2;
           end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("in_ready",  64'(in_ready),  64'(m_phase == 1));
      chk("out_valid", 64'(out_valid), 64'(m_phase == 2));
      chk("busy",      64'(busy),      64'(m_phase != 0));
      chk("acc_out",   64'(acc_out),   clip(m_total));
      chk("overflow",  64'(overflow),  64'(m_total > ACC_MAX));
    end
  end

  // Runs one transaction; returns the number of edges from start to out_valid.
  task automatic run(input int n, input logic [MUL_WIDTH-1:0] prods[],
                     input int gap, input int hold, output int lat);
    int t0;
    int guard;
    start     = 1'b1;
    num_terms = COUNT_WIDTH'(n);
    t0        = edge_cnt;
    @(negedge clk);
    start     = 1'b0;
    num_terms = COUNT_WIDTH'(n + 3);
    for (int i = 0; i < prods.size(); i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          mul_in   = 32'hDEAD_0000;
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      mul_in   = prods[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("out_valid_timeout", 64'(out_valid), 64'd1);
    lat = edge_cnt - t0;
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start     = (h % 3 == 1);
      @(negedge clk);
    end
    start     = (hold > 0);
    out_ready = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b0;
    chk("idle_after_handshake", 64'(busy), 64'd0);
  endtask

  logic [MUL_WIDTH-1:0] p4[]   = '{32'd3, 32'd5, 32'd7, 32'd9};
  logic [MUL_WIDTH-1:0] ff5[]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                   32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [MUL_WIDTH-1:0] ff4[]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                   32'hFFFF_FFFF};
  logic [MUL_WIDTH-1:0] fr4[]  = '{32'd10, 32'd20, 32'd30, 32'd40};
  logic [MUL_WIDTH-1:0] none[] = '{};

  initial begin
    int lat;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_acc_out", 64'(acc_out), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);

    run(4, p4, 0, 0, lat);
    $display("txn back-to-back: acc_out=%0d overflow=%0d latency=%0d", acc_out, overflow, lat);
    chk("b2b_sum", 64'(acc_out), 64'd24);
    chk("b2b_latency", 64'(lat), 64'd5);

    run(4, p4, 3, 0, lat);
    $display("txn gapped: acc_out=%0d latency=%0d", acc_out, lat);
    chk("gap_sum", 64'(acc_out), 64'd24);
    chk("gap_latency", 64'(lat), 64'd14);

    run(5, ff5, 0, 0, lat);
    $display("txn saturate5: acc_out=0x%0h overflow=%0d", acc_out, overflow);
    chk("sat5_acc", 64'(acc_out), 64'h3_FFFF_FFFF);
    chk("sat5_ovf", 64'(overflow), 64'd1);

    run(4, ff4, 0, 0, lat);
    $display("txn saturate4: acc_out=0x%0h overflow=%0d", acc_out, overflow);
    chk("sat4_acc", 64'(acc_out), 64'h3_FFFF_FFFC);
    chk("sat4_ovf", 64'(overflow), 64'd0);

    run(4, p4, 0, 10, lat);
    $display("txn backpressure: acc_out=%0d busy=%0d", acc_out, busy);
    chk("bp_sum", 64'(acc_out), 64'd24);

    in_valid = 1'b1;
    mul_in   = 32'd77;
    run(0, none, 0, 2, lat);
    in_valid = 1'b0;
    $display("txn zero-terms: acc_out=%0d latency=%0d", acc_out, lat);
    chk("zero_acc", 64'(acc_out), 64'd0);
    chk("zero_latency", 64'(lat), 64'd1);

    start     = 1'b1;
    num_terms = 8'd4;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    mul_in   = 32'd10;
    @(negedge clk);
    mul_in   = 32'd20;
    @(negedge clk);
    rst      = 1'b1;
    mul_in   = 32'd30;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    $display("txn abort: acc_out=%0d busy=%0d out_valid=%0d", acc_out, busy, out_valid);
    chk("abort_acc", 64'(acc_out), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("abort_no_result", 64'(out_valid), 64'd0);

    run(4, fr4, 1, 0, lat);
    $display("txn fresh: acc_out=%0d overflow=%0d", acc_out, overflow);
    chk("fresh_sum", 64'(acc_out), 64'd100);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
